// File: rtl/node_injection_queue.sv
// Network interface for one mesh node: a DEPTH-entry injection FIFO feeding the router's
// local input port, a registered ejection stage, and saturating tx/rx/drop statistics.
module node_injection_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int PKT_W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] i_pkt,
  input  logic             i_pkt_val,
  output logic             o_pkt_ready,
  output logic [PKT_W-1:0] o_data,
  output logic             o_data_val,
  input  logic             i_en,
  input  logic [PKT_W-1:0] i_data,
  input  logic             i_data_val,
  output logic [PKT_W-1:0] o_rx_data,
  output logic             o_rx_val,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_drop_count
);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PKT_W-1:0] rx_data_q;
  logic             rx_val_q;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             push, pop, drop;

  // Full is decided on the registered count alone, so a pop in the same cycle cannot make room.
  assign o_full      = (count_q == CW'(DEPTH));
  assign o_empty     = (count_q == '0);
  assign o_pkt_ready = !o_full;
  assign o_data_val  = !o_empty;
  assign o_data      = o_empty ? '0 : mem_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_val    = rx_val_q;
  assign o_tx_count  = tx_cnt_q;
  assign o_rx_count  = rx_cnt_q;
  assign o_drop_count = drop_cnt_q;

  assign push = i_pkt_val && !o_full;
  assign pop  = o_data_val && i_en;
  assign drop = i_pkt_val && o_full;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (pop && tx_cnt_q != '1)          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    if (i_data_val && rx_cnt_q != '1)   rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    if (drop && drop_cnt_q != '1)       drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= '0;
      rx_val_q   <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= i_data;
      rx_val_q   <= i_data_val;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; count gates whether it is ever read.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= i_pkt;
  end

endmodule

// File: tb/tb_node_injection_queue.sv
// Directed self-checking bench for node_injection_queue (DEPTH=4, CNT_W=4 so rx saturation
// is reachable in a few cycles).
module tb_node_injection_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int PKT_W = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [PKT_W-1:0] i_pkt;
  logic             i_pkt_val;
  logic             o_pkt_ready;
  logic [PKT_W-1:0] o_data;
  logic             o_data_val;
  logic             i_en;
  logic [PKT_W-1:0] i_data;
  logic             i_data_val;
  logic [PKT_W-1:0] o_rx_data;
  logic             o_rx_val;
  logic [CW-1:0]    o_count;
  logic             o_full, o_empty;
  logic [CNT_W-1:0] o_tx_count, o_rx_count, o_drop_count;

  int nChecks = 0;
  int nBad    = 0;

  node_injection_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PKT_W(PKT_W)) dut (
    .clk(clk), .reset(reset),
    .i_pkt(i_pkt), .i_pkt_val(i_pkt_val), .o_pkt_ready(o_pkt_ready),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
    .i_data(i_data), .i_data_val(i_data_val),
    .o_rx_data(o_rx_data), .o_rx_val(o_rx_val),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; i_pkt_val = 1'b0; i_en = 1'b0; i_data_val = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_pkt_val = 1'b1; i_pkt = 32'hDEAD; i_en = 1'b0; i_data_val = 1'b0; i_data = '0;
    tick();
    tick();
    nChecks++;
    if (o_empty !== 1'b1 || o_data_val !== 1'b0 || o_count !== 3'd0 || o_full !== 1'b0 ||
        o_pkt_ready !== 1'b1 || o_data !== 32'h0 || o_rx_val !== 1'b0 || o_rx_data !== 32'h0) begin
      nBad++;
      $display("[TB] FAIL reset_fifo: empty=%b val=%b count=%0d full=%b ready=%b data=%h rxv=%b rxd=%h, need 1 0 0 0 1 0 0 0",
               o_empty, o_data_val, o_count, o_full, o_pkt_ready, o_data, o_rx_val, o_rx_data);
    end
    nChecks++;
    if (o_tx_count !== 4'd0 || o_rx_count !== 4'd0 || o_drop_count !== 4'd0) begin
      nBad++;
      $display("[TB] FAIL reset_counters: tx=%0d rx=%0d drop=%0d, need 0 0 0", o_tx_count, o_rx_count, o_drop_count);
    end
    reset = 1'b0; i_pkt_val = 1'b0;
  endtask

  task automatic test_fill();
    i_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_pkt = 32'hA0 + k; i_pkt_val = 1'b1;
      tick();
      nChecks++;
      if (o_count !== CW'(k + 1) || o_data !== 32'hA0 || o_data_val !== 1'b1) begin
        nBad++;
        $display("[TB] FAIL fill_step%0d: count=%0d data=%h val=%b, need %0d 000000a0 1", k, o_count, o_data, o_data_val, k + 1);
      end
    end
    i_pkt = 32'hE0;
    tick();
    i_pkt_val = 1'b0;
    nChecks++;
    if (o_full !== 1'b1 || o_pkt_ready !== 1'b0 || o_drop_count !== 4'd1 || o_data !== 32'hA0 || o_count !== 3'd4) begin
      nBad++;
      $display("[TB] FAIL fill_overflow: full=%b ready=%b drop=%0d data=%h count=%0d, need 1 0 1 000000a0 4",
               o_full, o_pkt_ready, o_drop_count, o_data, o_count);
    end
  endtask

  task automatic test_drain();
    logic [4:0]  enSeq;
    logic [31:0] expHead [5];
    enSeq = 5'b11101;
    expHead = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
    for (int k = 0; k < 5; k++) begin
      i_en = enSeq[k];
      nChecks++;
      if (o_data !== expHead[k] || o_data_val !== 1'b1) begin
        nBad++;
        $display("[TB] FAIL drain_head%0d: data=%h val=%b, need %h 1", k, o_data, o_data_val, expHead[k]);
      end
      tick();
    end
    nChecks++;
    if (o_tx_count !== 4'd4 || o_empty !== 1'b1 || o_data_val !== 1'b0 || o_data !== 32'h0) begin
      nBad++;
      $display("[TB] FAIL drain_end: tx=%0d empty=%b val=%b data=%h, need 4 1 0 0", o_tx_count, o_empty, o_data_val, o_data);
    end
    tick();
    i_en = 1'b0;
    nChecks++;
    if (o_tx_count !== 4'd4 || o_count !== 3'd0) begin
      nBad++;
      $display("[TB] FAIL en_on_empty: tx=%0d count=%0d, need 4 0", o_tx_count, o_count);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    i_en = 1'b0; i_pkt_val = 1'b1;
    i_pkt = 32'h100; tick();
    i_pkt = 32'h101; tick();
    i_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_pkt = 32'h102 + k;
      nChecks++;
      if (o_data !== 32'h100 + k) begin
        nBad++;
        $display("[TB] FAIL b2b_head%0d: data=%h, need %h", k, o_data, 32'h100 + k);
      end
      tick();
      nChecks++;
      if (o_count !== 3'd2) begin
        nBad++;
        $display("[TB] FAIL b2b_count%0d: count=%0d, need 2", k, o_count);
      end
    end
    i_pkt_val = 1'b0;
    nChecks++;
    if (o_tx_count !== 4'd10 || o_data !== 32'h10A) begin
      nBad++;
      $display("[TB] FAIL b2b_end: tx=%0d data=%h, need 10 0000010a", o_tx_count, o_data);
    end
    tick();
    nChecks++;
    if (o_data !== 32'h10B || o_count !== 3'd1) begin
      nBad++;
      $display("[TB] FAIL b2b_tail: data=%h count=%0d, need 0000010b 1", o_data, o_count);
    end
    i_en = 1'b0;
  endtask

  task automatic test_full_pop();
    doReset();
    i_en = 1'b0; i_pkt_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_pkt = 32'h200 + k; tick();
    end
    i_pkt = 32'h2FF; i_en = 1'b1;
    tick();
    i_pkt_val = 1'b0;
    nChecks++;
    if (o_count !== 3'd3 || o_drop_count !== 4'd1 || o_tx_count !== 4'd1 || o_data !== 32'h201) begin
      nBad++;
      $display("[TB] FAIL full_pop: count=%0d drop=%0d tx=%0d data=%h, need 3 1 1 00000201", o_count, o_drop_count, o_tx_count, o_data);
    end
    for (int k = 1; k < 4; k++) begin
      nChecks++;
      if (o_data !== 32'h200 + k) begin
        nBad++;
        $display("[TB] FAIL full_pop_order%0d: data=%h, need %h", k, o_data, 32'h200 + k);
      end
      tick();
    end
    i_en = 1'b0;
    nChecks++;
    if (o_empty !== 1'b1) begin
      nBad++;
      $display("[TB] FAIL full_pop_empty: empty=%b, need 1", o_empty);
    end
  endtask

  task automatic test_mid_reset();
    i_en = 1'b0; i_pkt_val = 1'b1; i_pkt = 32'h300;
    tick();
    i_pkt_val = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++;
    if (o_data_val !== 1'b0 || o_count !== 3'd0 || o_data !== 32'h0) begin
      nBad++;
      $display("[TB] FAIL mid_reset: val=%b count=%0d data=%h, need 0 0 0", o_data_val, o_count, o_data);
    end
  endtask

  task automatic test_eject();
    doReset();
    i_data = 32'hABCD; i_data_val = 1'b1;
    tick();
    i_data = 32'h1111; i_data_val = 1'b0;
    nChecks++;
    if (o_rx_val !== 1'b1 || o_rx_data !== 32'hABCD || o_rx_count !== 4'd1) begin
      nBad++;
      $display("[TB] FAIL eject_pulse: rxv=%b rxd=%h rxc=%0d, need 1 0000abcd 1", o_rx_val, o_rx_data, o_rx_count);
    end
    tick();
    nChecks++;
    if (o_rx_val !== 1'b0 || o_rx_count !== 4'd1) begin
      nBad++;
      $display("[TB] FAIL eject_idle: rxv=%b rxc=%0d, need 0 1", o_rx_val, o_rx_count);
    end
    i_data_val = 1'b1;
    for (int k = 0; k < 19; k++) begin
      i_data = 32'h500 + k; tick();
    end
    i_data_val = 1'b0;
    nChecks++;
    if (o_rx_count !== 4'd15 || o_rx_data !== 32'h512) begin
      nBad++;
      $display("[TB] FAIL rx_saturate: rxc=%0d rxd=%h, need 15 00000512", o_rx_count, o_rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_pop();
    test_mid_reset();
    test_eject();
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
